// File: rtl/rvfpm_issue_queue_if.sv
// XIF issue/commit and execute-side signal bundle for the rvfpm issue queue.
// The slave modport is the queue itself; the master modport is whatever drives it.
interface rvfpm_issue_queue_if #(
  parameter int DEPTH      = 4,
  parameter int X_ID_WIDTH = 4,
  parameter int INSTR_W    = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  flush;
  logic                  issue_valid;
  logic                  issue_ready;
  logic [INSTR_W-1:0]    issue_instr;
  logic [X_ID_WIDTH-1:0] issue_id;
  logic                  issue_accept;
  logic                  commit_valid;
  logic [X_ID_WIDTH-1:0] commit_id;
  logic                  commit_kill;
  logic                  out_valid;
  logic                  out_ready;
  logic [INSTR_W-1:0]    out_instr;
  logic [X_ID_WIDTH-1:0] out_id;
  logic [CNT_W-1:0]      occupancy;
  logic                  commit_err;

  modport master (
    output flush, issue_valid, issue_instr, issue_id, issue_accept,
           commit_valid, commit_id, commit_kill, out_ready,
    input  issue_ready, out_valid, out_instr, out_id, occupancy, commit_err
  );

  modport slave (
    input  flush, issue_valid, issue_instr, issue_id, issue_accept,
           commit_valid, commit_id, commit_kill, out_ready,
    output issue_ready, out_valid, out_instr, out_id, occupancy, commit_err
  );
endinterface

// File: rtl/rvfpm_issue_queue.sv
// In-order issue/commit queue: holds offloaded instructions until committed, releases
// committed heads to execute and silently discards killed heads, one per cycle.
module rvfpm_issue_queue #(
  parameter int DEPTH      = 4,
  parameter int X_ID_WIDTH = 4,
  parameter int INSTR_W    = 32
) (
  input logic               ck,
  input logic               rst,
  rvfpm_issue_queue_if.slave xif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {H_EMPTY, H_WAIT, H_READY, H_DROP} head_st_e;

  logic [INSTR_W-1:0]    instr_q [DEPTH];
  logic [X_ID_WIDTH-1:0] id_q    [DEPTH];
  logic [DEPTH-1:0]      vld_q, vld_d, cmt_q, cmt_d, kil_q, kil_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  push, retire, byp_hit, hit;
  head_st_e              head_st;

  always_comb begin
    head_st = H_EMPTY;
    if (vld_q[head_q]) begin
      if (kil_q[head_q])      head_st = H_DROP;
      else if (cmt_q[head_q]) head_st = H_READY;
      else                    head_st = H_WAIT;
    end
  end

  // No bypass: a full queue stays not-ready even when the head pops this cycle.
  assign xif.issue_ready = (cnt_q != CNT_W'(DEPTH));
  assign push            = xif.issue_valid & xif.issue_ready & xif.issue_accept;
  assign xif.out_valid   = (head_st == H_READY);
  assign retire          = (head_st == H_DROP) | ((head_st == H_READY) & xif.out_ready);
  assign byp_hit         = xif.commit_valid & push & (xif.issue_id == xif.commit_id);
  assign xif.out_instr   = (head_st == H_EMPTY) ? '0 : instr_q[head_q];
  assign xif.out_id      = (head_st == H_EMPTY) ? '0 : id_q[head_q];
  assign xif.occupancy   = cnt_q;
  assign xif.commit_err  = err_q;

  always_comb begin
    vld_d  = vld_q;
    cmt_d  = cmt_q;
    kil_d  = kil_q;
    head_d = head_q;
    tail_d = tail_q;
    err_d  = err_q;
    hit    = byp_hit;
    for (int i = 0; i < DEPTH; i++) begin
      if (xif.commit_valid && vld_q[i] && (id_q[i] == xif.commit_id)) begin
        hit = 1'b1;
        if (xif.commit_kill) kil_d[i] = 1'b1;
        else                 cmt_d[i] = 1'b1;
      end
    end
    if (xif.commit_valid && !hit) err_d = 1'b1;
    if (retire) begin
      vld_d[head_q] = 1'b0;
      cmt_d[head_q] = 1'b0;
      kil_d[head_q] = 1'b0;
      head_d        = head_q + PTR_W'(1);
    end
    // Tail slot is never the retiring head: that would need a push into a full queue.
    if (push) begin
      vld_d[tail_q] = 1'b1;
      cmt_d[tail_q] = byp_hit & ~xif.commit_kill;
      kil_d[tail_q] = byp_hit & xif.commit_kill;
      tail_d        = tail_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(retire);
    if (xif.flush) begin
      vld_d  = '0;
      cmt_d  = '0;
      kil_d  = '0;
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      vld_q  <= '0;
      cmt_q  <= '0;
      kil_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      cmt_q  <= cmt_d;
      kil_q  <= kil_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Payload is only observed through valid flags, so it carries no reset.
  always_ff @(posedge ck) begin
    if (push && !xif.flush) begin
      instr_q[tail_q] <= xif.issue_instr;
      id_q[tail_q]    <= xif.issue_id;
    end
  end
endmodule

// File: tb/tb_rvfpm_issue_queue.sv
// Directed bench for rvfpm_issue_queue: expected releases are queued at issue time and
// a negedge monitor compares every handshake against them.
module tb_rvfpm_issue_queue;
  localparam int DEPTH = 4;
  localparam int XW    = 4;
  localparam int IW    = 32;

  logic ck  = 1'b0;
  logic rst = 1'b0;
  always #5 ck = ~ck;

  rvfpm_issue_queue_if #(.DEPTH(DEPTH), .X_ID_WIDTH(XW), .INSTR_W(IW)) bus ();

  rvfpm_issue_queue #(.DEPTH(DEPTH), .X_ID_WIDTH(XW), .INSTR_W(IW)) dut (
    .ck (ck),
    .rst(rst),
    .xif(bus)
  );

  typedef struct packed {
    logic [XW-1:0] id;
    logic [IW-1:0] instr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [IW-1:0] mk(input int id);
    return 32'hC0DE_0000 + IW'(id * 17);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic push(input int id, input bit will_out);
    bus.issue_valid  = 1'b1;
    bus.issue_accept = 1'b1;
    bus.issue_id     = XW'(id);
    bus.issue_instr  = mk(id);
    if (will_out) sb.push_back('{id: XW'(id), instr: mk(id)});
    tick();
    bus.issue_valid  = 1'b0;
    bus.issue_accept = 1'b0;
  endtask

  task automatic commit(input int id, input bit kill);
    bus.commit_valid = 1'b1;
    bus.commit_id    = XW'(id);
    bus.commit_kill  = kill;
    tick();
    bus.commit_valid = 1'b0;
    bus.commit_kill  = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge ck);
      if (rst && !bus.flush && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got id %0d, required no release", bus.out_id);
        end else begin
          e = sb.pop_front();
          chk("out_id", 64'(bus.out_id), 64'(e.id));
          chk("out_instr", 64'(bus.out_instr), 64'(e.instr));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.flush        = 1'b0;
    bus.issue_valid  = 1'b0;
    bus.issue_instr  = '0;
    bus.issue_id     = '0;
    bus.issue_accept = 1'b0;
    bus.commit_valid = 1'b0;
    bus.commit_id    = '0;
    bus.commit_kill  = 1'b0;
    bus.out_ready    = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // reset state
    chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
    chk("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
    chk("rst_out_id", 64'(bus.out_id), 64'd0);
    chk("rst_commit_err", 64'(bus.commit_err), 64'd0);

    // in-order release despite out-of-order commit
    bus.out_ready = 1'b1;
    push(1, 1'b1);
    push(2, 1'b1);
    push(3, 1'b1);
    chk("t2_occupancy3", 64'(bus.occupancy), 64'd3);
    chk("t2_wait_valid", 64'(bus.out_valid), 64'd0);
    commit(2, 1'b0);
    chk("t2_head_uncommitted", 64'(bus.out_valid), 64'd0);
    commit(1, 1'b0);
    chk("t2_head_ready", 64'(bus.out_valid), 64'd1);
    tick();
    tick();
    chk("t2_id3_holds", 64'(bus.out_valid), 64'd0);
    chk("t2_occupancy1", 64'(bus.occupancy), 64'd1);
    chk("t2_no_err", 64'(bus.commit_err), 64'd0);

    // fill to DEPTH, overflow attempt, pop frees a slot
    bus.out_ready = 1'b0;
    push(10, 1'b0);
    push(11, 1'b0);
    push(12, 1'b0);
    chk("t3_full_occ", 64'(bus.occupancy), 64'd4);
    chk("t3_full_ready", 64'(bus.issue_ready), 64'd0);
    push(13, 1'b0);
    chk("t3_overflow_ignored", 64'(bus.occupancy), 64'd4);
    commit(3, 1'b0);
    chk("t3_head_valid", 64'(bus.out_valid), 64'd1);
    chk("t3_head_id", 64'(bus.out_id), 64'd3);
    tick();
    chk("t3_hold_valid", 64'(bus.out_valid), 64'd1);
    chk("t3_hold_id", 64'(bus.out_id), 64'd3);
    chk("t3_hold_instr", 64'(bus.out_instr), 64'(mk(3)));
    chk("t3_still_full", 64'(bus.issue_ready), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t3_ready_after_pop", 64'(bus.issue_ready), 64'd1);
    chk("t3_occ_after_pop", 64'(bus.occupancy), 64'd3);

    // unmatched commit is sticky; flush clears it and drops 3 live entries
    commit(9, 1'b0);
    chk("t5_err_set", 64'(bus.commit_err), 64'd1);
    tick();
    chk("t5_err_sticky", 64'(bus.commit_err), 64'd1);
    bus.flush        = 1'b1;
    bus.issue_valid  = 1'b1;
    bus.issue_accept = 1'b1;
    bus.issue_id     = XW'(14);
    bus.issue_instr  = mk(14);
    bus.commit_valid = 1'b1;
    bus.commit_id    = XW'(10);
    tick();
    bus.flush        = 1'b0;
    bus.issue_valid  = 1'b0;
    bus.issue_accept = 1'b0;
    bus.commit_valid = 1'b0;
    chk("t6_flush_occ", 64'(bus.occupancy), 64'd0);
    chk("t6_flush_err", 64'(bus.commit_err), 64'd0);
    chk("t6_flush_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_flush_ready", 64'(bus.issue_ready), 64'd1);

    // kill drops the head in one cycle without out_valid
    bus.out_ready = 1'b1;
    push(5, 1'b0);
    push(6, 1'b1);
    chk("t4_occ2", 64'(bus.occupancy), 64'd2);
    commit(5, 1'b1);
    chk("t4_drop_no_valid", 64'(bus.out_valid), 64'd0);
    chk("t4_occ2_before_drop", 64'(bus.occupancy), 64'd2);
    tick();
    chk("t4_occ1_after_drop", 64'(bus.occupancy), 64'd1);
    commit(6, 1'b0);
    chk("t4_id6_valid", 64'(bus.out_valid), 64'd1);
    chk("t4_id6_id", 64'(bus.out_id), 64'd6);
    tick();
    chk("t4_occ0", 64'(bus.occupancy), 64'd0);
    chk("t4_no_err", 64'(bus.commit_err), 64'd0);

    // rejected by predecoder
    bus.issue_valid  = 1'b1;
    bus.issue_accept = 1'b0;
    bus.issue_id     = XW'(15);
    bus.issue_instr  = mk(15);
    tick();
    bus.issue_valid  = 1'b0;
    chk("t5_no_accept_occ", 64'(bus.occupancy), 64'd0);
    chk("t5_no_accept_valid", 64'(bus.out_valid), 64'd0);

    // commit bypassed onto the entry being pushed into an empty queue
    bus.out_ready    = 1'b0;
    bus.issue_valid  = 1'b1;
    bus.issue_accept = 1'b1;
    bus.issue_id     = XW'(7);
    bus.issue_instr  = mk(7);
    bus.commit_valid = 1'b1;
    bus.commit_id    = XW'(7);
    bus.commit_kill  = 1'b0;
    sb.push_back('{id: XW'(7), instr: mk(7)});
    tick();
    bus.issue_valid  = 1'b0;
    bus.issue_accept = 1'b0;
    bus.commit_valid = 1'b0;
    chk("t6_bypass_valid", 64'(bus.out_valid), 64'd1);
    chk("t6_bypass_id", 64'(bus.out_id), 64'd7);
    chk("t6_bypass_err", 64'(bus.commit_err), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("t6_bypass_popped", 64'(bus.occupancy), 64'd0);

    // asynchronous reset mid-traffic
    push(4, 1'b0);
    push(8, 1'b0);
    commit(4, 1'b0);
    bus.out_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("t1_async_occ", 64'(bus.occupancy), 64'd0);
    chk("t1_async_valid", 64'(bus.out_valid), 64'd0);
    chk("t1_async_ready", 64'(bus.issue_ready), 64'd1);
    chk("t1_async_instr", 64'(bus.out_instr), 64'd0);
    #3;
    rst = 1'b1;
    tick();
    tick();
    chk("t1_after_release_occ", 64'(bus.occupancy), 64'd0);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
